// File: rtl/graphics_pkg.sv
// rtl/graphics_pkg.sv - shared screen constants, accumulator widths and tracker states
package graphics_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int CNT_W  = 19;
  localparam int SUMX_W = 29;
  localparam int SUMY_W = 28;
  localparam int DIV_W  = 29;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV_X,
    ST_DIV_Y,
    ST_FILTER,
    ST_UPDATE
  } state_t;

  // Quotient to a 12-bit signed coordinate; anything beyond 11 bits saturates high
  function automatic logic signed [11:0] quot_to_s12(input logic [DIV_W-1:0] q);
    if (|q[DIV_W-1:11]) return 12'sh7ff;
    return $signed({1'b0, q[10:0]});
  endfunction

endpackage

// File: rtl/motion_centroid_tracker_if.sv
// rtl/motion_centroid_tracker_if.sv - pixel stream in, sprite position out
interface motion_centroid_tracker_if;

  logic       enable;
  logic [9:0] iVGA_X;
  logic [8:0] iVGA_Y;
  logic       iVal;
  logic       iMotion;
  logic       iFrameEnd;
  logic [9:0] oTopLeft_X;
  logic [8:0] oTopLeft_Y;
  logic       oUpdate;
  logic       oTracking;
  logic       oBusy;
  logic       oDropped;

  modport master (
    output enable, iVGA_X, iVGA_Y, iVal, iMotion, iFrameEnd,
    input  oTopLeft_X, oTopLeft_Y, oUpdate, oTracking, oBusy, oDropped
  );

  modport slave (
    input  enable, iVGA_X, iVGA_Y, iVal, iMotion, iFrameEnd,
    output oTopLeft_X, oTopLeft_Y, oUpdate, oTracking, oBusy, oDropped
  );

endinterface

// File: rtl/serial_udiv.sv
// rtl/serial_udiv.sv - fixed-latency restoring unsigned divider, one quotient bit per clock
module serial_udiv #(
  parameter int W = 29
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = $clog2(W + 1);

  logic [W:0]    r_rem;
  logic [W-1:0]  r_q;
  logic [CW-1:0] r_cnt;
  logic [W:0]    w_rem_in, w_shift, w_rem_nx;
  logic [W-1:0]  w_q_in, w_q_nx;
  logic          w_ge;

  // One restoring step; start feeds the fresh dividend so the first bit resolves on the start edge
  always_comb begin
    w_rem_in = start ? '0 : r_rem;
    w_q_in   = start ? dividend : r_q;
    w_shift  = {w_rem_in[W-1:0], w_q_in[W-1]};
    w_ge     = (w_shift >= {1'b0, divisor});
    w_rem_nx = w_ge ? (w_shift - {1'b0, divisor}) : w_shift;
    w_q_nx   = {w_q_in[W-2:0], w_ge};
  end

  // Quotient bits shift in where dividend bits shift out; r_cnt counts the remaining steps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem <= '0;
      r_q   <= '0;
      r_cnt <= '0;
    end else if (start) begin
      r_rem <= w_rem_nx;
      r_q   <= w_q_nx;
      r_cnt <= CW'(W - 1);
    end else if (r_cnt != '0) begin
      r_rem <= w_rem_nx;
      r_q   <= w_q_nx;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign done     = (r_cnt == CW'(1));
  assign quotient = r_q;

endmodule

// File: rtl/motion_centroid_tracker.sv
// rtl/motion_centroid_tracker.sv - per-frame motion centroid to clamped, smoothed sprite top-left
module motion_centroid_tracker
  import graphics_pkg::*;
#(
  parameter int SPRITE_W     = 110,
  parameter int SPRITE_H     = 220,
  parameter int INIT_X       = 265,
  parameter int INIT_Y       = 130,
  parameter int MIN_PIXELS   = 64,
  parameter int LOST_FRAMES  = 8,
  parameter int SMOOTH_SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  motion_centroid_tracker_if.slave bus
);

  localparam int LOST_W = $clog2(LOST_FRAMES + 1);
  localparam logic signed [11:0] X_MAX  = 12'(SCREEN_W - SPRITE_W);
  localparam logic signed [11:0] Y_MAX  = 12'(SCREEN_H - SPRITE_H);
  localparam logic signed [11:0] HALF_W = 12'(SPRITE_W / 2);
  localparam logic signed [11:0] HALF_H = 12'(SPRITE_H / 2);

  state_t              r_state, w_next;
  logic                w_pix, w_fe, w_valid, w_go_home;
  logic [CNT_W-1:0]    r_cnt, r_snap_cnt;
  logic [SUMX_W-1:0]   r_sum_x, r_snap_x;
  logic [SUMY_W-1:0]   r_sum_y, r_snap_y;
  logic [LOST_W-1:0]   r_lost;
  logic                r_div_start, w_div_done;
  logic [DIV_W-1:0]    w_dividend, w_divisor, w_quot;
  logic signed [11:0]  r_cx, w_cy, w_tx, w_ty, w_cl_x, w_cl_y, w_base_x, w_base_y;
  logic [9:0]          r_new_x, r_top_x, w_fx;
  logic [8:0]          r_new_y, r_top_y, w_fy;
  logic                r_new_trk, r_pub, r_trk, r_upd, r_drop;

  assign w_pix     = bus.enable & bus.iVal & bus.iMotion;
  assign w_fe      = bus.enable & bus.iFrameEnd;
  assign w_valid   = (r_cnt >= CNT_W'(MIN_PIXELS));
  assign w_go_home = (r_lost == LOST_W'(LOST_FRAMES - 1));

  // Live accumulators; a frame end restarts them, and a pixel on that same edge opens the new frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_sum_x <= '0;
      r_sum_y <= '0;
    end else begin
      r_cnt   <= (w_fe ? '0 : r_cnt) + CNT_W'(w_pix);
      r_sum_x <= (w_fe ? '0 : r_sum_x) + (w_pix ? SUMX_W'(bus.iVGA_X) : '0);
      r_sum_y <= (w_fe ? '0 : r_sum_y) + (w_pix ? SUMY_W'(bus.iVGA_Y) : '0);
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state; frames too sparse to track take a single UPDATE cycle that may or may not publish
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_fe) w_next = w_valid ? ST_DIV_X : ST_UPDATE;
      ST_DIV_X:  if (w_div_done) w_next = ST_DIV_Y;
      ST_DIV_Y:  if (w_div_done) w_next = ST_FILTER;
      ST_FILTER: w_next = ST_UPDATE;
      default:   w_next = ST_IDLE;
    endcase
  end

  assign w_dividend = (r_state == ST_DIV_Y) ? DIV_W'(r_snap_y) : DIV_W'(r_snap_x);
  assign w_divisor  = DIV_W'(r_snap_cnt);

  serial_udiv #(.W(DIV_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (r_div_start),
    .dividend (w_dividend),
    .divisor  (w_divisor),
    .done     (w_div_done),
    .quotient (w_quot)
  );

  // Centroid to top-left, clamp to the screen, then move a 2^-SMOOTH_SHIFT fraction toward it
  always_comb begin
    w_cy     = quot_to_s12(w_quot);
    w_tx     = r_cx - HALF_W;
    w_ty     = w_cy - HALF_H;
    w_cl_x   = (w_tx < 0) ? 12'sd0 : ((w_tx > X_MAX) ? X_MAX : w_tx);
    w_cl_y   = (w_ty < 0) ? 12'sd0 : ((w_ty > Y_MAX) ? Y_MAX : w_ty);
    w_base_x = $signed({2'b00, r_top_x});
    w_base_y = $signed({3'b000, r_top_y});
    w_fx     = 10'(w_base_x + ((w_cl_x - w_base_x) >>> SMOOTH_SHIFT));
    w_fy     = 9'(w_base_y + ((w_cl_y - w_base_y) >>> SMOOTH_SHIFT));
  end

  // Snapshot, divider sequencing, loss counting and the once-per-frame publish
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snap_cnt  <= '0;
      r_snap_x    <= '0;
      r_snap_y    <= '0;
      r_lost      <= '0;
      r_div_start <= 1'b0;
      r_cx        <= '0;
      r_new_x     <= 10'(INIT_X);
      r_new_y     <= 9'(INIT_Y);
      r_new_trk   <= 1'b0;
      r_pub       <= 1'b0;
      r_top_x     <= 10'(INIT_X);
      r_top_y     <= 9'(INIT_Y);
      r_trk       <= 1'b0;
      r_upd       <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_div_start <= 1'b0;
      r_upd       <= 1'b0;
      r_drop      <= w_fe && (r_state != ST_IDLE);
      unique case (r_state)
        ST_IDLE: if (w_fe) begin
          r_snap_cnt <= r_cnt;
          r_snap_x   <= r_sum_x;
          r_snap_y   <= r_sum_y;
          if (w_valid) begin
            r_div_start <= 1'b1;
          end else begin
            r_pub     <= w_go_home;
            r_new_x   <= 10'(INIT_X);
            r_new_y   <= 9'(INIT_Y);
            r_new_trk <= 1'b0;
            if (r_lost != LOST_W'(LOST_FRAMES)) r_lost <= r_lost + 1'b1;
          end
        end
        ST_DIV_X: if (w_div_done) r_div_start <= 1'b1;
        ST_DIV_Y: if (r_div_start) r_cx <= quot_to_s12(w_quot);
        ST_FILTER: begin
          r_new_x   <= w_fx;
          r_new_y   <= w_fy;
          r_new_trk <= 1'b1;
          r_pub     <= 1'b1;
        end
        default: if (r_pub) begin
          r_top_x <= r_new_x;
          r_top_y <= r_new_y;
          r_trk   <= r_new_trk;
          r_upd   <= 1'b1;
          if (r_new_trk) r_lost <= '0;
        end
      endcase
    end
  end

  assign bus.oTopLeft_X = r_top_x;
  assign bus.oTopLeft_Y = r_top_y;
  assign bus.oUpdate    = r_upd;
  assign bus.oTracking  = r_trk;
  assign bus.oBusy      = (r_state != ST_IDLE);
  assign bus.oDropped   = r_drop;

endmodule

// File: tb/tb_motion_centroid_tracker.sv
// tb/tb_motion_centroid_tracker.sv - randomized bench against a frame-level centroid model
`timescale 1ns/1ps
module tb_motion_centroid_tracker;
  import graphics_pkg::*;

  localparam int SPRITE_W    = 110;
  localparam int SPRITE_H    = 220;
  localparam int INIT_X      = 265;
  localparam int INIT_Y      = 130;
  localparam int MIN_PIXELS  = 64;
  localparam int LOST_FRAMES = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable, val, mot, fe;
  logic [9:0] vx;
  logic [8:0] vy;

  always #5 clk = ~clk;

  motion_centroid_tracker_if bus0 ();
  motion_centroid_tracker_if bus1 ();

  assign bus0.enable = enable;  assign bus1.enable = enable;
  assign bus0.iVGA_X = vx;      assign bus1.iVGA_X = vx;
  assign bus0.iVGA_Y = vy;      assign bus1.iVGA_Y = vy;
  assign bus0.iVal = val;       assign bus1.iVal = val;
  assign bus0.iMotion = mot;    assign bus1.iMotion = mot;
  assign bus0.iFrameEnd = fe;   assign bus1.iFrameEnd = fe;

  motion_centroid_tracker #(.SMOOTH_SHIFT(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  motion_centroid_tracker #(.SMOOTH_SHIFT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int n_total = 0;
  int n_bad = 0;

  int m_cnt, m_sx, m_sy;
  int m_px[2];
  int m_py[2];
  int m_trk, m_lost, e_upd, e_at;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_home();
    for (int s = 0; s < 2; s++) begin
      m_px[s] = INIT_X;
      m_py[s] = INIT_Y;
    end
    m_trk = 0; m_lost = 0; m_cnt = 0; m_sx = 0; m_sy = 0;
  endtask

  // Frame verdict from the frame's totals: mean position, sprite offset, clamp, fractional step
  task automatic model_frame();
    int tx, ty;
    if (m_cnt >= MIN_PIXELS) begin
      tx = clampi(m_sx / m_cnt - SPRITE_W / 2, 0, SCREEN_W - SPRITE_W);
      ty = clampi(m_sy / m_cnt - SPRITE_H / 2, 0, SCREEN_H - SPRITE_H);
      for (int s = 0; s < 2; s++) begin
        m_px[s] = m_px[s] + ((tx - m_px[s]) >>> s);
        m_py[s] = m_py[s] + ((ty - m_py[s]) >>> s);
      end
      m_trk = 1; m_lost = 0; e_upd = 1; e_at = 60;
    end else begin
      e_upd = 0; e_at = -1;
      if (m_lost == LOST_FRAMES - 1) begin
        for (int s = 0; s < 2; s++) begin
          m_px[s] = INIT_X;
          m_py[s] = INIT_Y;
        end
        m_trk = 0; e_upd = 1; e_at = 1;
      end
      if (m_lost < LOST_FRAMES) m_lost++;
    end
    m_cnt = 0; m_sx = 0; m_sy = 0;
  endtask

  task automatic drive(input bit en, input bit v, input bit m, input bit f, input int x, input int y);
    enable = en; val = v; mot = m; fe = f;
    vx = 10'(x); vy = 9'(y);
    @(negedge clk);
  endtask

  // One counted motion pixel, sometimes preceded by a cycle that must not count
  task automatic pixel(input int x, input int y);
    case ($urandom_range(7))
      0: drive(1'b1, 1'b1, 1'b0, 1'b0, $urandom_range(639), $urandom_range(479));
      1: drive(1'b1, 1'b0, 1'b1, 1'b0, $urandom_range(639), $urandom_range(479));
      2: drive(1'b0, 1'b1, 1'b1, 1'($urandom_range(1)), $urandom_range(639), $urandom_range(479));
      default: ;
    endcase
    drive(1'b1, 1'b1, 1'b1, 1'b0, x, y);
    m_cnt++; m_sx += x; m_sy += y;
  endtask

  task automatic blob(input int x0, input int y0, input int w, input int h);
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++)
        pixel(x0 + xx, y0 + yy);
  endtask

  task automatic check_pos(input string tag);
    chk({tag, "_x0"}, int'(bus0.oTopLeft_X), m_px[0]);
    chk({tag, "_y0"}, int'(bus0.oTopLeft_Y), m_py[0]);
    chk({tag, "_trk0"}, int'(bus0.oTracking), m_trk);
    chk({tag, "_x1"}, int'(bus1.oTopLeft_X), m_px[1]);
    chk({tag, "_y1"}, int'(bus1.oTopLeft_Y), m_py[1]);
    chk({tag, "_trk1"}, int'(bus1.oTracking), m_trk);
  endtask

  // Frame end at E0, then 70 observed cycles; drop_at > 0 injects a second frame end at that edge
  task automatic finish_frame(input int drop_at, input bit e0_pix, input string tag);
    int nu0, nu1, at, nd, dk, x, y;
    nu0 = 0; nu1 = 0; at = -1; nd = 0; dk = -1;
    model_frame();
    if (e0_pix) begin
      x = $urandom_range(639); y = $urandom_range(479);
      drive(1'b1, 1'b1, 1'b1, 1'b1, x, y);
      m_cnt = 1; m_sx = x; m_sy = y;
    end else begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
    end
    for (int k = 0; k < 70; k++) begin
      if (bus0.oUpdate) begin nu0++; at = k; end
      if (bus1.oUpdate) nu1++;
      if (bus0.oDropped) begin nd++; dk = k; end
      if (drop_at > 0 && k < drop_at - 1)       drive(1'b1, 1'b1, 1'b1, 1'b0, 600, 470);
      else if (drop_at > 0 && k == drop_at - 1) drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
      else                                      drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    end
    if (drop_at > 0) begin
      m_cnt = 0; m_sx = 0; m_sy = 0;
      chk({tag, "_drop_at"}, dk, drop_at);
    end
    chk({tag, "_drops"}, nd, (drop_at > 0) ? 1 : 0);
    chk({tag, "_upd0"}, nu0, e_upd);
    chk({tag, "_upd1"}, nu1, e_upd);
    if (e_upd == 1) chk({tag, "_upd_lat"}, at, e_at);
    chk({tag, "_idle0"}, int'(bus0.oBusy), 0);
    chk({tag, "_idle1"}, int'(bus1.oBusy), 0);
    check_pos(tag);
  endtask

  // Reset lands while the X/Y divide is running; nothing may publish
  task automatic reset_mid();
    int nu;
    nu = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
    for (int k = 0; k < 39; k++) begin
      if (bus0.oUpdate || bus1.oUpdate) nu++;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    end
    chk("rst_busy_before", int'(bus0.oBusy), 1);
    reset = 1'b1;
    #1;
    model_home();
    chk("rst_busy", int'(bus0.oBusy), 0);
    chk("rst_upd", int'(bus0.oUpdate), 0);
    check_pos("rst_mid");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    reset = 1'b0;
    for (int k = 0; k < 70; k++) begin
      if (bus0.oUpdate || bus1.oUpdate) nu++;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    end
    chk("rst_no_upd", nu, 0);
    check_pos("rst_after");
  endtask

  task automatic random_frame(input string tag);
    int w, h;
    if ($urandom_range(1) == 0) begin
      w = $urandom_range(24, 3); h = $urandom_range(24, 3);
      blob($urandom_range(640 - w), $urandom_range(480 - h), w, h);
    end else begin
      repeat ($urandom_range(90)) pixel($urandom_range(639), $urandom_range(479));
    end
    finish_frame(0, 1'($urandom_range(1)), tag);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    enable = 1'b0; val = 1'b0; mot = 1'b0; fe = 1'b0; vx = '0; vy = '0;
    model_home();
    repeat (3) @(negedge clk);
    chk("rst_upd0", int'(bus0.oUpdate), 0);
    chk("rst_busy0", int'(bus0.oBusy), 0);
    chk("rst_drop0", int'(bus0.oDropped), 0);
    check_pos("reset");
    reset = 1'b0;
    @(negedge clk);

    drive(1'b0, 1'b1, 1'b1, 1'b1, 5, 5);
    chk("disabled_fe_busy", int'(bus0.oBusy), 0);

    blob(300, 200, 20, 20);
    finish_frame(0, 1'b0, "t1");
    chk("t1_x_abs", int'(bus0.oTopLeft_X), 254);
    chk("t1_y_abs", int'(bus0.oTopLeft_Y), 99);
    chk("t2_x_abs", int'(bus1.oTopLeft_X), 259);
    chk("t2_y_abs", int'(bus1.oTopLeft_Y), 114);

    blob(0, 470, 10, 10);
    finish_frame(0, 1'b0, "t3");
    chk("t3_x_abs", int'(bus0.oTopLeft_X), 0);
    chk("t3_y_abs", int'(bus0.oTopLeft_Y), 260);

    for (int f = 0; f < 8; f++) begin
      blob(100, 100, 10, 1);
      finish_frame(0, 1'b0, $sformatf("t4_f%0d", f));
    end
    chk("t4_home_x", int'(bus0.oTopLeft_X), INIT_X);
    chk("t4_home_y", int'(bus0.oTopLeft_Y), INIT_Y);
    chk("t4_lost_trk", int'(bus0.oTracking), 0);

    for (int f = 0; f < 6; f++) random_frame($sformatf("rnd_a%0d", f));

    blob(300, 200, 20, 20);
    finish_frame(10, 1'b0, "t5");
    blob(400, 100, 16, 16);
    finish_frame(0, 1'b0, "t5_next");

    blob(120, 300, 12, 12);
    reset_mid();
    blob(500, 50, 14, 14);
    finish_frame(0, 1'b0, "t6_next");

    for (int f = 0; f < 6; f++) random_frame($sformatf("rnd_b%0d", f));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
